// File: rtl/bypass_regfile_sb_pkg.sv
// Shared constants and types for the decode-side operand unit: register file geometry,
// forwarding window size and scoreboard counter width.
package bypass_regfile_sb_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int AW       = $clog2(NREG);
    localparam int NRD      = 2;
    localparam int NFWD     = 3;
    localparam int PEND_W   = 2;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    localparam logic [AW-1:0] R0 = '0;

    // Forwarding producers, youngest first; a lower index wins on a destination match.
    typedef enum int unsigned {
        FWD_EX  = 0,
        FWD_MEM = 1,
        FWD_WB  = 2
    } fwd_idx_e;

endpackage

// File: rtl/bypass_regfile_sb_operand_resolve.sv
// Resolves one read port: youngest matching producer, then the same-cycle retire write,
// then the scoreboard, then the register file.
module operand_resolve
    import bypass_regfile_sb_pkg::*;
(
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 pend_busy,
    input  logic [XLEN-1:0]      rf_data,
    output logic [XLEN-1:0]      rd_data,
    output logic                 rd_stall
);

    logic fwd_hit;

    // NOTE: every output of this block is given a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        rd_data  = '0;
        rd_stall = 1'b0;
        fwd_hit  = 1'b0;
        if (rd_en && rd_addr != R0) begin
            for (int k = int'(FWD_EX); k < NFWD; k++) begin
                if (!fwd_hit && fwd_valid[k] && fwd_dest[k*AW +: AW] == rd_addr) begin
                    fwd_hit = 1'b1;
                    if (fwd_ready[k]) begin
                        rd_data = fwd_data[k*XLEN +: XLEN];
                    end else begin
                        rd_stall = 1'b1;
                    end
                end
            end
            if (!fwd_hit) begin
                if (wb_we && wb_addr == rd_addr) begin
                    rd_data = wb_data;
                end else if (pend_busy) begin
                    // Writer is in flight but outside the forwarding window.
                    rd_stall = 1'b1;
                end else begin
                    rd_data = rf_data;
                end
            end
        end
    end

endmodule

// File: rtl/bypass_regfile_sb.sv
// Decode operand unit: GPR file, per-register pending-write scoreboard, forwarding
// network (one resolver per read port) and RAW interlock.
module bypass_regfile_sb
    import bypass_regfile_sb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic                 rd_stall,
    input  logic                 iss_fire,
    input  logic                 iss_we,
    input  logic [AW-1:0]        iss_dest,
    output logic                 iss_block,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*AW-1:0]   fwd_dest,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 can_valid,
    input  logic [AW-1:0]        can_dest,
    output logic                 sb_err
);

    localparam int CW = PEND_W + 2;

    logic [XLEN-1:0]   gpr_q  [NREG];
    logic [XLEN-1:0]   gpr_d  [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];
    logic              sb_err_q;
    logic              sb_err_d;
    logic [NRD-1:0]    port_stall;

    always_comb begin
        gpr_d = gpr_q;
        if (wb_we && wb_addr != R0) begin
            gpr_d[wb_addr] = wb_data;
        end
    end

    // Net count change per register; the extra two bits hold the signed range -2..PEND_MAX+1.
    always_comb begin : pend_next
        logic signed [CW-1:0] cnt;
        logic                 inc;
        logic [1:0]           dec;
        cnt      = '0;
        inc      = 1'b0;
        dec      = '0;
        pend_d   = pend_q;
        sb_err_d = sb_err_q;
        pend_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = iss_fire && iss_we && (iss_dest == AW'(r));
            dec = {1'b0, wb_we && (wb_addr == AW'(r))}
                + {1'b0, can_valid && (can_dest == AW'(r))};
            cnt = CW'(pend_q[r]) + CW'(inc) - CW'(dec);
            if (cnt < 0) begin
                pend_d[r] = '0;
                sb_err_d  = 1'b1;
            end else if (cnt > CW'(PEND_MAX)) begin
                pend_d[r] = PEND_W'(PEND_MAX);
                sb_err_d  = 1'b1;
            end else begin
                pend_d[r] = cnt[PEND_W-1:0];
            end
        end
    end

    // A retire or cancel to the same register frees a slot this cycle, so no hold is needed.
    always_comb begin
        iss_block = iss_we && (iss_dest != R0)
                 && (pend_q[iss_dest] == PEND_W'(PEND_MAX))
                 && !(wb_we && wb_addr == iss_dest)
                 && !(can_valid && can_dest == iss_dest);
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process ordering.
    // NOTE: the register array is cleared on reset because architectural state must read
    // as zero afterwards; this costs a reset path on every GPR bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpr_q    <= '{default: '0};
            pend_q   <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            gpr_q    <= gpr_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = rd_addr[i*AW +: AW];

        operand_resolve u_resolve (
            .rd_en     (rd_en[i]),
            .rd_addr   (addr),
            .fwd_valid (fwd_valid),
            .fwd_dest  (fwd_dest),
            .fwd_ready (fwd_ready),
            .fwd_data  (fwd_data),
            .wb_we     (wb_we),
            .wb_addr   (wb_addr),
            .wb_data   (wb_data),
            .pend_busy (pend_q[addr] != '0),
            .rf_data   (gpr_q[addr]),
            .rd_data   (rd_data[i*XLEN +: XLEN]),
            .rd_stall  (port_stall[i])
        );
    end

    assign rd_stall = |port_stall;

endmodule

// File: tb/tb_bypass_regfile_sb.sv
// Self-checking bench: directed table, multi-cycle corner sequences, then random traffic
// compared against a behavioural model of the register file and scoreboard.
module tb_bypass_regfile_sb;
    import bypass_regfile_sb_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic                 rd_stall;
    logic                 iss_fire, iss_we;
    logic [AW-1:0]        iss_dest;
    logic                 iss_block;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0]   fwd_dest;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_we;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 can_valid;
    logic [AW-1:0]        can_dest;
    logic                 sb_err;

    bypass_regfile_sb dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_stall(rd_stall), .iss_fire(iss_fire), .iss_we(iss_we), .iss_dest(iss_dest),
        .iss_block(iss_block), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_ready(fwd_ready), .fwd_data(fwd_data), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .can_valid(can_valid), .can_dest(can_dest), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: architectural values, outstanding-writer counts, sticky error.
    logic [XLEN-1:0] m_gpr [NREG];
    int              m_pend[NREG];
    bit              m_err;

    typedef struct {
        logic [NRD-1:0]       en;
        logic [AW-1:0]        a0, a1;
        logic [NFWD-1:0]      fv, fr;
        logic [NFWD*AW-1:0]   fd;
        logic [NFWD*XLEN-1:0] fdat;
        logic                 wbe;
        logic [AW-1:0]        wba;
        logic [XLEN-1:0]      wbd;
        logic                 iss;
        logic [XLEN-1:0]      e_d0, e_d1;
        logic                 e_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        iss_fire = 1'b0; iss_we = 1'b0; iss_dest = '0;
        fwd_valid = '0; fwd_dest = '0; fwd_ready = '0; fwd_data = '0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        can_valid = 1'b0; can_dest = '0;
    endtask

    function automatic void m_read(input int i, output logic [XLEN-1:0] d, output bit st);
        logic [AW-1:0] a;
        a  = rd_addr[i*AW +: AW];
        d  = '0;
        st = 1'b0;
        if (!rd_en[i] || a == 0) return;
        for (int k = 0; k < NFWD; k++) begin
            if (fwd_valid[k] && fwd_dest[k*AW +: AW] == a) begin
                if (fwd_ready[k]) d = fwd_data[k*XLEN +: XLEN];
                else st = 1'b1;
                return;
            end
        end
        if (wb_we && wb_addr == a) begin
            d = wb_data;
            return;
        end
        if (m_pend[a] != 0) begin
            st = 1'b1;
            return;
        end
        d = m_gpr[a];
    endfunction

    function automatic bit m_block();
        return iss_we && iss_dest != 0 && m_pend[iss_dest] == PEND_MAX
            && !(wb_we && wb_addr == iss_dest) && !(can_valid && can_dest == iss_dest);
    endfunction

    // Advance one clock: the model's next state comes from the inputs held across the edge.
    task automatic tick();
        logic [XLEN-1:0] ngpr [NREG];
        int              npend[NREG];
        bit              nerr;
        int              v;
        ngpr  = m_gpr;
        npend = m_pend;
        nerr  = m_err;
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                ngpr[r]  = '0;
                npend[r] = 0;
            end
            nerr = 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                v = m_pend[r];
                if (iss_fire && iss_we && iss_dest == r) v = v + 1;
                if (wb_we && wb_addr == r) v = v - 1;
                if (can_valid && can_dest == r) v = v - 1;
                if (v < 0) begin
                    npend[r] = 0;
                    nerr = 1'b1;
                end else if (v > PEND_MAX) begin
                    npend[r] = PEND_MAX;
                    nerr = 1'b1;
                end else begin
                    npend[r] = v;
                end
            end
            if (wb_we && wb_addr != 0) ngpr[wb_addr] = wb_data;
        end
        @(posedge clk);
        m_gpr  = ngpr;
        m_pend = npend;
        m_err  = nerr;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [XLEN-1:0] d;
        bit st;
        bit any_st;
        any_st = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            m_read(i, d, st);
            any_st |= st;
            if (!st) check($sformatf("%s_d%0d", tag, i), rd_data[i*XLEN +: XLEN], d);
        end
        check({tag, "_stall"}, 32'(rd_stall), 32'(any_st));
        check({tag, "_block"}, 32'(iss_block), 32'(m_block()));
        check({tag, "_err"}, 32'(sb_err), 32'(m_err));
    endtask

    function automatic vec_t mk(
        input logic [NRD-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
        input logic [NFWD-1:0] fv, input logic [NFWD*AW-1:0] fd, input logic [NFWD-1:0] fr,
        input logic [NFWD*XLEN-1:0] fdat, input logic wbe, input logic [AW-1:0] wba,
        input logic [XLEN-1:0] wbd, input logic iss, input logic [XLEN-1:0] e_d0,
        input logic [XLEN-1:0] e_d1, input logic e_stall);
        vec_t v;
        v.en = en; v.a0 = a0; v.a1 = a1; v.fv = fv; v.fd = fd; v.fr = fr; v.fdat = fdat;
        v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.iss = iss;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_stall = e_stall;
        return v;
    endfunction

    // Rows that retire also issue to the same register so the count nets to zero.
    task automatic run_vec(input int idx, input vec_t v);
        idle();
        rd_en = v.en; rd_addr = {v.a1, v.a0};
        fwd_valid = v.fv; fwd_dest = v.fd; fwd_ready = v.fr; fwd_data = v.fdat;
        wb_we = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
        iss_fire = v.iss; iss_we = v.iss; iss_dest = v.wba;
        #2;
        check($sformatf("vec%0d_stall", idx), 32'(rd_stall), 32'(v.e_stall));
        if (!v.e_stall) begin
            check($sformatf("vec%0d_d0", idx), rd_data[XLEN-1:0], v.e_d0);
            check($sformatf("vec%0d_d1", idx), rd_data[2*XLEN-1:XLEN], v.e_d1);
        end
        tick();
    endtask

    task automatic issue(input logic [AW-1:0] r);
        idle(); iss_fire = 1'b1; iss_we = 1'b1; iss_dest = r; tick();
    endtask

    task automatic retire(input logic [AW-1:0] r, input logic [XLEN-1:0] d);
        idle(); wb_we = 1'b1; wb_addr = r; wb_data = d; tick();
    endtask

    task automatic read0(input logic [AW-1:0] r);
        idle(); rd_en = 2'b01; rd_addr = {AW'(0), r}; #2;
    endtask

    initial begin
        logic [AW-1:0] pick;

        vecs[0] = mk(2'b01, 5'd5, 5'd0, 3'b000, '0, 3'b000, '0, 0, 0, 0, 0, 32'h1234, 0, 0);
        vecs[1] = mk(2'b01, 5'd7, 5'd0, 3'b101, {5'd7, 5'd0, 5'd7}, 3'b111,
                     {32'hBBBB, 32'h0, 32'hAAAA}, 0, 0, 0, 0, 32'hAAAA, 0, 0);
        vecs[2] = mk(2'b10, 5'd0, 5'd3, 3'b001, {5'd0, 5'd0, 5'd3}, 3'b000, '0,
                     0, 0, 0, 0, 0, 0, 1);
        vecs[3] = mk(2'b00, 5'd0, 5'd3, 3'b001, {5'd0, 5'd0, 5'd3}, 3'b000, '0,
                     0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(2'b01, 5'd0, 5'd0, 3'b001, '0, 3'b001, {32'h0, 32'h0, 32'hFFFF},
                     0, 0, 0, 0, 0, 0, 0);
        vecs[5] = mk(2'b11, 5'd7, 5'd5, 3'b110, {5'd7, 5'd7, 5'd0}, 3'b100,
                     {32'hCCCC, 32'h0, 32'h0}, 0, 0, 0, 0, 0, 0, 1);
        vecs[6] = mk(2'b11, 5'd7, 5'd3, 3'b100, {5'd7, 5'd0, 5'd0}, 3'b100,
                     {32'hCCCC, 32'h0, 32'h0}, 1, 5'd7, 32'hDDDD, 1, 32'hCCCC, 32'h3333, 0);
        vecs[7] = mk(2'b11, 5'd7, 5'd3, 3'b000, '0, 3'b000, '0,
                     1, 5'd3, 32'h5555, 1, 32'hDDDD, 32'h5555, 0);
        vecs[8] = mk(2'b11, 5'd3, 5'd7, 3'b000, '0, 3'b000, '0, 0, 0, 0, 0,
                     32'h5555, 32'hDDDD, 0);
        vecs[9] = mk(2'b10, 5'd0, 5'd5, 3'b010, {5'd0, 5'd5, 5'd0}, 3'b010,
                     {32'h0, 32'h9999, 32'h0}, 0, 0, 0, 0, 0, 32'h9999, 0);

        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        idle(); rd_en = 2'b11; rd_addr = {AW'(31), AW'(1)}; iss_we = 1'b1; iss_dest = 5'd4; #2;
        check("rst_d0", rd_data[XLEN-1:0], 32'h0);
        check("rst_d1", rd_data[2*XLEN-1:XLEN], 32'h0);
        check("rst_stall", 32'(rd_stall), 32'h0);
        check("rst_block", 32'(iss_block), 32'h0);
        check("rst_err", 32'(sb_err), 32'h0);
        tick();

        // Legal issue-then-retire setup so the table sees r3/r5/r7 populated and idle.
        issue(5'd3); issue(5'd5); issue(5'd7);
        retire(5'd5, 32'h1234); retire(5'd7, 32'h7777); retire(5'd3, 32'h3333);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
        idle(); #2;
        check("table_err", 32'(sb_err), 32'h0);

        // Long-latency writer to r9 outside the forwarding window.
        issue(5'd9);
        for (int c = 0; c < 3; c++) begin
            read0(5'd9);
            check($sformatf("div_wait%0d_stall", c), 32'(rd_stall), 32'h1);
            tick();
        end
        read0(5'd9); wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h42; #1;
        check("div_wb_d0", rd_data[XLEN-1:0], 32'h42);
        check("div_wb_stall", 32'(rd_stall), 32'h0);
        tick();
        read0(5'd9);
        check("div_after_d0", rd_data[XLEN-1:0], 32'h42);
        check("div_after_stall", 32'(rd_stall), 32'h0);
        tick();

        // Issue, retire and cancel to r6 in one cycle with one write already pending.
        issue(5'd6);
        idle(); iss_fire = 1'b1; iss_we = 1'b1; iss_dest = 5'd6;
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h66; can_valid = 1'b1; can_dest = 5'd6;
        tick();
        read0(5'd6);
        check("net_d0", rd_data[XLEN-1:0], 32'h66);
        check("net_stall", 32'(rd_stall), 32'h0);
        check("net_err", 32'(sb_err), 32'h0);
        tick();

        // r0 traffic is ignored everywhere.
        idle(); iss_fire = 1'b1; iss_we = 1'b1; iss_dest = R0;
        wb_we = 1'b1; wb_addr = R0; wb_data = 32'hDEAD; can_valid = 1'b1; can_dest = R0; #2;
        check("r0_block", 32'(iss_block), 32'h0);
        tick();
        idle(); rd_en = 2'b11; rd_addr = '0; #2;
        check("r0_d0", rd_data[XLEN-1:0], 32'h0);
        check("r0_d1", rd_data[2*XLEN-1:XLEN], 32'h0);
        check("r0_stall", 32'(rd_stall), 32'h0);
        check("r0_err", 32'(sb_err), 32'h0);
        tick();

        // Saturate r4, then violate the hold.
        issue(5'd4); issue(5'd4); issue(5'd4);
        idle(); iss_we = 1'b1; iss_dest = 5'd4; #2;
        check("sat_block", 32'(iss_block), 32'h1);
        wb_we = 1'b1; wb_addr = 5'd4; #1;
        check("sat_block_wb", 32'(iss_block), 32'h0);
        wb_we = 1'b0; #1;
        check("sat_err_pre", 32'(sb_err), 32'h0);
        iss_fire = 1'b1;
        tick();
        idle(); rd_en = 2'b01; rd_addr = {AW'(0), AW'(4)}; #2;
        check("ovf_err", 32'(sb_err), 32'h1);
        check("ovf_stall", 32'(rd_stall), 32'h1);
        tick();

        // Reset in the middle of traffic.
        idle(); reset = 1'b1; iss_fire = 1'b1; iss_we = 1'b1; iss_dest = 5'd8;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hBEEF;
        tick();
        reset = 1'b0;
        idle(); rd_en = 2'b11; rd_addr = {AW'(4), AW'(5)}; iss_we = 1'b1; iss_dest = 5'd4; #2;
        check("mrst_err", 32'(sb_err), 32'h0);
        check("mrst_stall", 32'(rd_stall), 32'h0);
        check("mrst_d0", rd_data[XLEN-1:0], 32'h0);
        check("mrst_block", 32'(iss_block), 32'h0);
        tick();

        // Random traffic on a narrow register range to force collisions.
        for (int c = 0; c < 600; c++) begin
            idle();
            rd_en   = NRD'($urandom);
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            fwd_valid = NFWD'($urandom);
            for (int k = 0; k < NFWD; k++) begin
                fwd_dest[k*AW +: AW]   = AW'($urandom_range(0, 7));
                fwd_ready[k]           = ($urandom_range(0, 3) != 0);
                fwd_data[k*XLEN +: XLEN] = $urandom;
            end
            pick    = AW'($urandom_range(0, 7));
            wb_addr = pick;
            wb_data = $urandom;
            wb_we   = (m_pend[pick] > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            pick      = AW'($urandom_range(0, 7));
            can_dest  = pick;
            can_valid = (m_pend[pick] > 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
            iss_we   = ($urandom_range(0, 3) != 0);
            iss_dest = AW'($urandom_range(0, 7));
            iss_fire = (($urandom_range(0, 2) == 0) && !m_block()) || ($urandom_range(0, 99) == 0);
            #2;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
